// File: rtl/combinational_logic.sv
// Programmable 3-input LUT with a registered copy and a saturating count of cycles with F high.
// Latency: F is combinational, 0 cycles; F_q and f_count follow F by one clock edge.
// Backpressure: none; the LUT accepts a write on every edge where lut_we is set.
module combinational_logic #(
    parameter logic [7:0] LUT_INIT = 8'b1001_0110,
    parameter int         CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             A,
    input  logic             B,
    input  logic             C,
    input  logic             lut_we,
    input  logic [7:0]       lut_wdata,
    input  logic             cnt_clr,
    output logic             F,
    output logic             F_q,
    output logic [7:0]       lut_rdata,
    output logic [CNT_W-1:0] f_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [7:0] lut;
    logic [2:0] lut_idx;

    assign lut_idx   = {A, B, C};
    assign F         = lut[lut_idx];
    assign lut_rdata = lut;

    // F_q and the counter both sample the pre-edge F, so a same-edge write never affects them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lut     <= LUT_INIT;
            F_q     <= 1'b0;
            f_count <= '0;
        end else begin
            if (lut_we) begin
                lut <= lut_wdata;
            end
            F_q <= F;
            if (cnt_clr) begin
                f_count <= '0;
            end else if (F && (f_count != CNT_MAX)) begin
                f_count <= f_count + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_combinational_logic.sv
// Directed checks of the LUT function unit: reset, parity sweep, writes, counter saturation and async reset.
module tb_combinational_logic;

    logic        clk = 1'b0;
    logic        rst;
    logic        A, B, C;
    logic        lut_we;
    logic [7:0]  lut_wdata;
    logic        cnt_clr;
    logic        F, F_q;
    logic [7:0]  lut_rdata;
    logic [15:0] f_count;
    logic        F4, F_q4;
    logic [7:0]  lut_rdata4;
    logic [3:0]  f_count4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    combinational_logic dut (
        .clk(clk), .rst(rst), .A(A), .B(B), .C(C),
        .lut_we(lut_we), .lut_wdata(lut_wdata), .cnt_clr(cnt_clr),
        .F(F), .F_q(F_q), .lut_rdata(lut_rdata), .f_count(f_count)
    );

    combinational_logic #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .A(A), .B(B), .C(C),
        .lut_we(lut_we), .lut_wdata(lut_wdata), .cnt_clr(cnt_clr),
        .F(F4), .F_q(F_q4), .lut_rdata(lut_rdata4), .f_count(f_count4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_abc(input logic [2:0] v);
        {A, B, C} = v;
    endtask

    task automatic write_lut(input logic [7:0] v);
        lut_wdata = v;
        lut_we    = 1'b1;
        step();
        lut_we    = 1'b0;
    endtask

    initial begin
        logic [7:0] parity;
        parity = 8'b1001_0110;
        rst = 1'b1; lut_we = 1'b0; lut_wdata = 8'h00; cnt_clr = 1'b0;
        set_abc(3'b000);
        #2;
        check("rst_lut", {24'b0, lut_rdata}, 32'h96);
        check("rst_fq", {31'b0, F_q}, 32'h0);
        check("rst_cnt", {16'b0, f_count}, 32'h0);
        set_abc(3'b001);
        #5;
        check("rst_f_001", {31'b0, F}, 32'h1);

        @(negedge clk);
        rst = 1'b0;

        // Parity sweep: F combinational, F_q one edge behind.
        for (int i = 0; i < 8; i++) begin
            set_abc(i[2:0]);
            #1;
            check($sformatf("par_f_%0d", i), {31'b0, F}, {31'b0, parity[i]});
            step();
            check($sformatf("par_fq_%0d", i), {31'b0, F_q}, {31'b0, parity[i]});
        end

        write_lut(8'h01);
        check("wr_rdata", {24'b0, lut_rdata}, 32'h01);
        set_abc(3'b000);
        #1;
        check("wr_f_000", {31'b0, F}, 32'h1);
        set_abc(3'b001);
        #1;
        check("wr_f_001", {31'b0, F}, 32'h0);
        set_abc(3'b111);
        #1;
        check("wr_f_111", {31'b0, F}, 32'h0);

        // Same-edge write: F_q captures the old table's F.
        write_lut(8'h96);
        set_abc(3'b001);
        #1;
        check("se_f_pre", {31'b0, F}, 32'h1);
        write_lut(8'h00);
        check("se_fq_1", {31'b0, F_q}, 32'h1);
        check("se_f_post", {31'b0, F}, 32'h0);
        step();
        check("se_fq_2", {31'b0, F_q}, 32'h0);

        // Counter: clear, count 5, clear with F high.
        write_lut(8'hFF);
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        check("cnt_clr0", {16'b0, f_count}, 32'h0);
        repeat (5) step();
        check("cnt_5", {16'b0, f_count}, 32'h5);
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        check("cnt_clr_f1", {16'b0, f_count}, 32'h0);
        check("cnt4_clr_f1", {28'b0, f_count4}, 32'h0);
        repeat (20) step();
        check("cnt4_sat", {28'b0, f_count4}, 32'hF);
        check("cnt16_20", {16'b0, f_count}, 32'd20);

        // Simultaneous write and clear: both apply, counter ignores the new table.
        lut_wdata = 8'h00; lut_we = 1'b1; cnt_clr = 1'b1;
        step();
        lut_we = 1'b0; cnt_clr = 1'b0;
        check("wc_cnt", {16'b0, f_count}, 32'h0);
        check("wc_lut", {24'b0, lut_rdata}, 32'h00);

        // Build lut=00, f_count=3, then reset between edges.
        write_lut(8'hFF);
        step();
        step();
        write_lut(8'h00);
        check("mid_cnt3", {16'b0, f_count}, 32'h3);
        check("mid_lut00", {24'b0, lut_rdata}, 32'h00);
        check("mid_fq1", {31'b0, F_q}, 32'h1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_lut", {24'b0, lut_rdata}, 32'h96);
        check("mid_rst_fq", {31'b0, F_q}, 32'h0);
        check("mid_rst_cnt", {16'b0, f_count}, 32'h0);
        check("mid_rst_f", {31'b0, F}, 32'h1);
        step();
        check("mid_hold_fq", {31'b0, F_q}, 32'h0);
        check("mid_hold_cnt", {16'b0, f_count}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        step();
        check("rel_fq", {31'b0, F_q}, 32'h1);
        check("rel_cnt", {16'b0, f_count}, 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
